// File: rtl/nbody_csr_slave.sv
// nbody_csr_slave
//   Memory-mapped responder between the host bus and the n-body compute core.
//   Decodes addr[15:9] select codes, holds the control registers (GO, READ,
//   N_BODIES, GAP), merges 32-bit lower/upper halves into 64-bit doubles for
//   the body banks {VY,VX,M,Y,X}, and serves result readback with a fixed
//   two-cycle read latency.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   chipselect/write/read/addr/writedata   host bus request
//   readdata/readdatavalid                 registered read response
//   bank_we/bank_addr/bank_wdata           one-hot body bank write
//   go/read_mode/n_bodies/gap              control registers to the core
//   res_addr/res_x/res_y                   result memory read port
//   done_in                                core step-complete pulse
//   err                                    sticky protocol error
//
// Build option
//   NBODY_CSR_READBACK_EN : when defined, GO/READ/N_BODIES/GAP are readable;
//                           otherwise those reads return 0.
module nbody_csr_slave #(
    parameter int BODY_ADDR_WIDTH = 9,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic                       read,
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic [DATA_WIDTH-1:0]      writedata,
    output logic [DATA_WIDTH-1:0]      readdata,
    output logic                       readdatavalid,
    output logic [4:0]                 bank_we,
    output logic [BODY_ADDR_WIDTH-1:0] bank_addr,
    output logic [DATA_WIDTH-1:0]      bank_wdata,
    output logic                       go,
    output logic                       read_mode,
    output logic [9:0]                 n_bodies,
    output logic [31:0]                gap,
    output logic [BODY_ADDR_WIDTH-1:0] res_addr,
    input  logic [DATA_WIDTH-1:0]      res_x,
    input  logic [DATA_WIDTH-1:0]      res_y,
    input  logic                       done_in,
    output logic                       err
);

    typedef enum logic [6:0] {
        SEL_GO   = 7'h00, SEL_READ = 7'h01, SEL_NB   = 7'h02, SEL_GAP  = 7'h03,
        SEL_XL   = 7'h04, SEL_XU   = 7'h05, SEL_YL   = 7'h06, SEL_YU   = 7'h07,
        SEL_ML   = 7'h08, SEL_MU   = 7'h09, SEL_VXL  = 7'h10, SEL_VXU  = 7'h11,
        SEL_VYL  = 7'h12, SEL_VYU  = 7'h13, SEL_DONE = 7'h40, SEL_RXL  = 7'h41,
        SEL_RXU  = 7'h42, SEL_RYL  = 7'h43, SEL_RYU  = 7'h44
    } sel_e;

    sel_e                       w_sel;
    logic [BODY_ADDR_WIDTH-1:0] w_idx;
    logic                       w_wr, w_rd;
    logic                       w_body, w_upper;
    logic [2:0]                 w_bank;
    logic [4:0]                 w_onehot;
    logic                       w_match, w_repeat;
    logic [31:0]                w_lower;
    logic [DATA_WIDTH-1:0]      w_rd_data;
    logic                       w_unused;

    logic [DATA_WIDTH-1:0]      r_readdata;
    logic                       r_readdatavalid;
    logic [4:0]                 r_bank_we;
    logic [BODY_ADDR_WIDTH-1:0] r_bank_addr;
    logic [DATA_WIDTH-1:0]      r_bank_wdata;
    logic                       r_go, r_read_mode, r_err, r_done;
    logic [9:0]                 r_n_bodies;
    logic [31:0]                r_gap;
    logic [BODY_ADDR_WIDTH-1:0] r_res_addr;
    logic [31:0]                r_stage     [5];
    logic [BODY_ADDR_WIDTH-1:0] r_stage_idx [5];
    logic [4:0]                 r_stage_v;
    logic                       r_rd_v;
    sel_e                       r_rd_sel;
    logic                       r_prev_v;
    logic [ADDR_WIDTH-1:0]      r_prev_addr;
    logic [31:0]                r_prev_wd;

    assign w_sel    = sel_e'(addr[ADDR_WIDTH-1 -: 7]);
    assign w_idx    = addr[BODY_ADDR_WIDTH-1:0];
    assign w_wr     = chipselect & write;
    // A write in the same cycle wins; the read is dropped.
    assign w_rd     = chipselect & read & ~write;
    assign w_onehot = 5'b00001 << w_bank;
    assign w_match  = r_stage_v[w_bank] && (r_stage_idx[w_bank] == w_idx);
    assign w_lower  = w_match ? r_stage[w_bank] : 32'h0;
    // Same upper write held over consecutive cycles: the staged lower half was
    // consumed by the first commit, so replay the committed word instead.
    assign w_repeat = r_prev_v && (r_prev_addr == addr) && (r_prev_wd == writedata[31:0]);
    assign w_unused = &{1'b0, writedata[DATA_WIDTH-1:32]};

    always_comb begin
        w_body  = 1'b0;
        w_upper = 1'b0;
        w_bank  = 3'd0;
        case (w_sel)
            SEL_XL:  begin w_body = 1'b1;                  w_bank = 3'd0; end
            SEL_XU:  begin w_body = 1'b1; w_upper = 1'b1; w_bank = 3'd0; end
            SEL_YL:  begin w_body = 1'b1;                  w_bank = 3'd1; end
            SEL_YU:  begin w_body = 1'b1; w_upper = 1'b1; w_bank = 3'd1; end
            SEL_ML:  begin w_body = 1'b1;                  w_bank = 3'd2; end
            SEL_MU:  begin w_body = 1'b1; w_upper = 1'b1; w_bank = 3'd2; end
            SEL_VXL: begin w_body = 1'b1;                  w_bank = 3'd3; end
            SEL_VXU: begin w_body = 1'b1; w_upper = 1'b1; w_bank = 3'd3; end
            SEL_VYL: begin w_body = 1'b1;                  w_bank = 3'd4; end
            SEL_VYU: begin w_body = 1'b1; w_upper = 1'b1; w_bank = 3'd4; end
            default: ;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        case (r_rd_sel)
            SEL_RXL:  w_rd_data[31:0] = res_x[31:0];
            SEL_RXU:  w_rd_data[31:0] = res_x[63:32];
            SEL_RYL:  w_rd_data[31:0] = res_y[31:0];
            SEL_RYU:  w_rd_data[31:0] = res_y[63:32];
            SEL_DONE: w_rd_data[2:0]  = {r_err, r_go, r_done};
`ifdef NBODY_CSR_READBACK_EN
            SEL_GO:   w_rd_data[0]    = r_go;
            SEL_READ: w_rd_data[0]    = r_read_mode;
            SEL_NB:   w_rd_data[9:0]  = r_n_bodies;
            SEL_GAP:  w_rd_data[31:0] = r_gap;
`endif
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_bank_we       <= '0;
            r_bank_addr     <= '0;
            r_bank_wdata    <= '0;
            r_go            <= 1'b0;
            r_read_mode     <= 1'b0;
            r_n_bodies      <= '0;
            r_gap           <= '0;
            r_res_addr      <= '0;
            r_err           <= 1'b0;
            r_done          <= 1'b0;
            r_stage_v       <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                r_stage[i]     <= '0;
                r_stage_idx[i] <= '0;
            end
            r_rd_v          <= 1'b0;
            r_rd_sel        <= SEL_GO;
            r_prev_v        <= 1'b0;
            r_prev_addr     <= '0;
            r_prev_wd       <= '0;
        end else begin
            r_bank_we   <= '0;
            r_prev_v    <= w_wr;
            r_prev_addr <= addr;
            r_prev_wd   <= writedata[31:0];

            // done_in has priority over the GO=1 clear.
            if (done_in)
                r_done <= 1'b1;
            else if (w_wr && (w_sel == SEL_GO) && writedata[0])
                r_done <= 1'b0;

            if (w_wr) begin
                case (w_sel)
                    SEL_GO:   r_go        <= writedata[0];
                    SEL_READ: r_read_mode <= writedata[0];
                    SEL_NB:   r_n_bodies  <= writedata[9:0];
                    SEL_GAP:  r_gap       <= writedata[31:0];
                    SEL_DONE: if (writedata[0]) r_err <= 1'b0;
                    default:  ;
                endcase
                if (w_body) begin
                    if (r_go) begin
                        r_err <= 1'b1;
                    end else if (!w_upper) begin
                        r_stage[w_bank]     <= writedata[31:0];
                        r_stage_idx[w_bank] <= w_idx;
                        r_stage_v[w_bank]   <= 1'b1;
                    end else if (w_repeat) begin
                        r_bank_we <= w_onehot;
                    end else begin
                        r_bank_we         <= w_onehot;
                        r_bank_addr       <= w_idx;
                        r_bank_wdata      <= DATA_WIDTH'({writedata[31:0], w_lower});
                        r_stage_v[w_bank] <= 1'b0;
                        if (!w_match) r_err <= 1'b1;
                    end
                end
            end

            r_rd_v <= w_rd;
            if (w_rd) begin
                r_rd_sel   <= w_sel;
                r_res_addr <= w_idx;
            end
            r_readdatavalid <= r_rd_v;
            if (r_rd_v) r_readdata <= w_rd_data;
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;
    assign bank_we       = r_bank_we;
    assign bank_addr     = r_bank_addr;
    assign bank_wdata    = r_bank_wdata;
    assign go            = r_go;
    assign read_mode     = r_read_mode;
    assign n_bodies      = r_n_bodies;
    assign gap           = r_gap;
    assign res_addr      = r_res_addr;
    assign err           = r_err;

endmodule

// File: tb/tb_nbody_csr_slave.sv
// tb_nbody_csr_slave
//   Directed stimulus for nbody_csr_slave. Expected read responses and bank
//   writes are queued at issue time; monitors compare them when the DUT
//   presents readdatavalid or a bank_we pulse.
module tb_nbody_csr_slave;

    localparam logic [6:0] S_GO = 7'h00, S_READ = 7'h01, S_NB = 7'h02, S_GAP = 7'h03;
    localparam logic [6:0] S_XL = 7'h04, S_XU = 7'h05, S_YL = 7'h06, S_YU = 7'h07;
    localparam logic [6:0] S_ML = 7'h08, S_MU = 7'h09, S_VXL = 7'h10, S_VXU = 7'h11;
    localparam logic [6:0] S_VYL = 7'h12, S_VYU = 7'h13, S_DONE = 7'h40;
    localparam logic [6:0] S_RXL = 7'h41, S_RXU = 7'h42, S_RYL = 7'h43, S_RYU = 7'h44;

    logic        clk = 1'b0;
    logic        rst;
    logic        chipselect, write, read;
    logic [15:0] addr;
    logic [63:0] writedata;
    logic [63:0] readdata;
    logic        readdatavalid;
    logic [4:0]  bank_we;
    logic [8:0]  bank_addr;
    logic [63:0] bank_wdata;
    logic        go, read_mode;
    logic [9:0]  n_bodies;
    logic [31:0] gap;
    logic [8:0]  res_addr;
    logic [63:0] res_x, res_y;
    logic        done_in;
    logic        err;

    logic [63:0] mem_x [512];
    logic [63:0] mem_y [512];
    assign res_x = mem_x[res_addr];
    assign res_y = mem_y[res_addr];

    nbody_csr_slave #(.BODY_ADDR_WIDTH(9), .ADDR_WIDTH(16), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .chipselect(chipselect), .write(write), .read(read),
        .addr(addr), .writedata(writedata), .readdata(readdata),
        .readdatavalid(readdatavalid), .bank_we(bank_we), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .go(go), .read_mode(read_mode), .n_bodies(n_bodies),
        .gap(gap), .res_addr(res_addr), .res_x(res_x), .res_y(res_y),
        .done_in(done_in), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [63:0] d; int unsigned c; } rd_t;
    typedef struct { logic [4:0] we; logic [8:0] a; logic [63:0] d; } bk_t;
    rd_t rq[$];
    bk_t bq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Read monitor: data and exact two-cycle latency.
    rd_t re;
    bk_t be;
    always @(negedge clk) begin
        if (!rst && readdatavalid) begin
            if (rq.size() == 0) begin
                chk("unexpected_readdatavalid", readdata, 64'hx);
            end else begin
                re = rq.pop_front();
                chk("readdata", readdata, re.d);
                chk("read_latency", 64'(cyc), 64'(re.c + 2));
            end
        end
        if (!rst && bank_we != 5'b0) begin
            if (bq.size() == 0) begin
                chk("unexpected_bank_we", {50'b0, bank_we, bank_addr}, 64'h0);
            end else begin
                be = bq.pop_front();
                chk("bank_we", 64'(bank_we), 64'(be.we));
                chk("bank_addr", 64'(bank_addr), 64'(be.a));
                chk("bank_wdata", bank_wdata, be.d);
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
    endtask

    task automatic wr_cycle(input logic [6:0] sel, input logic [8:0] idx, input logic [63:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        addr = {sel, idx}; writedata = d;
    endtask

    task automatic rd_cycle(input logic [6:0] sel, input logic [8:0] idx, input logic [63:0] exp);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b0; read = 1'b1;
        addr = {sel, idx}; writedata = '0;
        rq.push_back('{d: exp, c: cyc});
    endtask

    task automatic exp_bank(input logic [4:0] we, input logic [8:0] a, input logic [63:0] d);
        bq.push_back('{we: we, a: a, d: d});
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_x[i] = '0;
            mem_y[i] = '0;
        end
        mem_x[0] = 64'h3FF0_0000_0000_0000;
        mem_x[5] = 64'h0123_4567_89AB_CDEF;
        mem_y[5] = 64'hFEDC_BA98_7654_3210;

        rst = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        addr = '0; writedata = '0; done_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 64'h0);
        chk("rst_rdv", 64'(readdatavalid), 64'h0);
        chk("rst_bank_we", 64'(bank_we), 64'h0);
        chk("rst_bank_addr", 64'(bank_addr), 64'h0);
        chk("rst_bank_wdata", bank_wdata, 64'h0);
        chk("rst_go_rm", {62'b0, go, read_mode}, 64'h0);
        chk("rst_n_bodies_gap", {22'b0, n_bodies, gap}, 64'h0);
        chk("rst_res_addr_err", {54'b0, res_addr, err}, 64'h0);
        rst = 1'b0;

        // Reset lands on the X upper cycle: nothing commits, staging cleared.
        wr_cycle(S_XL, 9'd3, 64'h1111);
        wr_cycle(S_XU, 9'd3, 64'h2222);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_bank_we", 64'(bank_we), 64'h0);
        chk("midrst_err_go", {62'b0, err, go}, 64'h0);
        chipselect = 1'b0; write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_bank(5'b00001, 9'd3, 64'h0000_2222_0000_0000);
        wr_cycle(S_XU, 9'd3, 64'h2222);
        rd_cycle(S_DONE, 9'd0, 64'h4);
        wr_cycle(S_DONE, 9'd0, 64'h1);
        rd_cycle(S_DONE, 9'd0, 64'h0);
        idle();

        // Control registers, then a body write while running.
        wr_cycle(S_NB, 9'd0, 64'd25);
        wr_cycle(S_GAP, 9'd0, 64'd6);
        wr_cycle(S_GO, 9'd0, 64'd1);
        wr_cycle(S_READ, 9'd0, 64'd1);
        idle();
        chk("n_bodies", 64'(n_bodies), 64'd25);
        chk("gap", 64'(gap), 64'd6);
        chk("go", 64'(go), 64'd1);
        chk("read_mode", 64'(read_mode), 64'd1);
`ifdef NBODY_CSR_READBACK_EN
        rd_cycle(S_NB, 9'd0, 64'd25);
        rd_cycle(S_GAP, 9'd0, 64'd6);
        rd_cycle(S_GO, 9'd0, 64'd1);
        rd_cycle(S_READ, 9'd0, 64'd1);
`else
        rd_cycle(S_NB, 9'd0, 64'd0);
        rd_cycle(S_GAP, 9'd0, 64'd0);
        rd_cycle(S_GO, 9'd0, 64'd0);
        rd_cycle(S_READ, 9'd0, 64'd0);
`endif
        wr_cycle(S_XL, 9'd0, 64'h1234);
        wr_cycle(S_XU, 9'd0, 64'h5678);
        idle();
        chk("err_go_body", 64'(err), 64'd1);
        wr_cycle(S_GO, 9'd0, 64'd0);
        wr_cycle(S_READ, 9'd0, 64'd0);
        wr_cycle(S_DONE, 9'd0, 64'd1);
        idle();
        chk("err_cleared", {62'b0, err, go}, 64'h0);

        // Body 1 X = -5.0; upper writedata bits above 31 must be ignored.
        exp_bank(5'b00001, 9'd1, 64'hC014_0000_0000_0000);
        wr_cycle(S_XL, 9'd1, 64'hDEAD_BEEF_0000_0000);
        wr_cycle(S_XU, 9'd1, 64'hFFFF_FFFF_C014_0000);
        idle();
        chk("err_after_x", 64'(err), 64'd0);

        // Interleaved staging across banks, plus M and VY.
        exp_bank(5'b00001, 9'd4, 64'hCCCC_0003_AAAA_0001);
        exp_bank(5'b00010, 9'd5, 64'hDDDD_0004_BBBB_0002);
        exp_bank(5'b00100, 9'd7, 64'h0000_0022_0000_0011);
        exp_bank(5'b10000, 9'd8, 64'h0000_0044_0000_0033);
        wr_cycle(S_XL, 9'd4, 64'hAAAA_0001);
        wr_cycle(S_YL, 9'd5, 64'hBBBB_0002);
        wr_cycle(S_XU, 9'd4, 64'hCCCC_0003);
        wr_cycle(S_YU, 9'd5, 64'hDDDD_0004);
        wr_cycle(S_ML, 9'd7, 64'h11);
        wr_cycle(S_MU, 9'd7, 64'h22);
        wr_cycle(S_VYL, 9'd8, 64'h33);
        wr_cycle(S_VYU, 9'd8, 64'h44);
        idle();
        chk("err_after_interleave", 64'(err), 64'd0);

        // VX upper index differs from staged lower index: lower forced to 0.
        exp_bank(5'b01000, 9'd10, 64'h0000_0066_0000_0000);
        wr_cycle(S_VXL, 9'd9, 64'h55);
        wr_cycle(S_VXU, 9'd10, 64'h66);
        // Y upper with nothing staged.
        exp_bank(5'b00010, 9'd2, 64'h4000_0000_0000_0000);
        wr_cycle(S_YU, 9'd2, 64'h4000_0000);
        rd_cycle(S_DONE, 9'd0, 64'h4);
        wr_cycle(S_DONE, 9'd0, 64'h1);
        idle();

        // Held writes: lower re-stages, upper recommits the same word.
        for (int i = 0; i < 3; i++) wr_cycle(S_ML, 9'd6, 64'h77);
        for (int i = 0; i < 3; i++) begin
            exp_bank(5'b00100, 9'd6, 64'h0000_0088_0000_0077);
            wr_cycle(S_MU, 9'd6, 64'h88);
        end
        idle();
        chk("err_after_hold", 64'(err), 64'd0);

        // Result readback with res_addr timing.
        rd_cycle(S_RXU, 9'd0, 64'h3FF0_0000);
        idle();
        chk("res_addr_t1", 64'(res_addr), 64'd0);
        chk("rdv_t1", 64'(readdatavalid), 64'd0);
        idle();

        // Back-to-back pipelined reads.
        rd_cycle(S_RXL, 9'd5, 64'h89AB_CDEF);
        rd_cycle(S_RXU, 9'd5, 64'h0123_4567);
        rd_cycle(S_RYL, 9'd5, 64'h7654_3210);
        rd_cycle(S_RYU, 9'd5, 64'hFEDC_BA98);
        rd_cycle(7'h20, 9'd5, 64'h0);
        rd_cycle(S_DONE, 9'd0, 64'h0);
        idle();

        // Read and write together: write happens, no response.
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; read = 1'b1;
        addr = {S_GAP, 9'd0}; writedata = 64'd7;
        idle();
        idle();
        idle();
        chk("gap_rw", 64'(gap), 64'd7);

        // done_sticky set/clear/priority.
        @(negedge clk); done_in = 1'b1;
        @(negedge clk); done_in = 1'b0;
        rd_cycle(S_DONE, 9'd0, 64'h1);
        wr_cycle(S_GO, 9'd0, 64'h1);
        rd_cycle(S_DONE, 9'd0, 64'h2);
        wr_cycle(S_GO, 9'd0, 64'h1);
        done_in = 1'b1;
        rd_cycle(S_DONE, 9'd0, 64'h3);
        done_in = 1'b0;
        wr_cycle(S_GO, 9'd0, 64'h0);
        rd_cycle(S_DONE, 9'd0, 64'h1);
        idle();

        repeat (5) @(negedge clk);
        chk("read_queue_drained", 64'(rq.size()), 64'd0);
        chk("bank_queue_drained", 64'(bq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nbody_csr_slave.md
Name: nbody_csr_slave

Overview:
Memory-mapped responder between the host bus and the n-body compute core. It decodes addr[15:9] select codes, holds the control registers (GO, READ, N_BODIES, GAP) and merges 32-bit lower/upper halves into 64-bit doubles written to the body banks X, Y, M, VX and VY. It also serves the result readback (DONE, X/Y lower/upper) with a fixed two-cycle read latency. One instance sits between the host interconnect and the core's body memories.

Parameters:
BODY_ADDR_WIDTH, 9, body index width; addr[BODY_ADDR_WIDTH-1:0] is the index.
ADDR_WIDTH, 16, bus address width; select field is addr[15:9].
DATA_WIDTH, 64, writedata/readdata width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
chipselect  in  1  bus select
write  in  1  write strobe, qualified by chipselect
read  in  1  read strobe, qualified by chipselect
addr  in  16  {select[6:0], index[8:0]}
writedata  in  64  write data; only [31:0] is used for body halves
readdata  out  64  read data, registered
readdatavalid  out  1  one-cycle pulse when readdata holds a new read result
bank_we  out  5  one-hot write enable {VY,VX,M,Y,X}
bank_addr  out  9  body index for bank write
bank_wdata  out  64  merged double {upper, lower}
go  out  1  run level to core
read_mode  out  1  READ register; core freezes results while 1
n_bodies  out  10  body count
gap  out  32  integration-step gap
res_addr  out  9  result memory read index
res_x  in  64  result X, valid 1 cycle after res_addr
res_y  in  64  result Y, valid 1 cycle after res_addr
done_in  in  1  core step-complete pulse
err  out  1  sticky protocol error

Behaviour:
- Reset (async): readdata=0, readdatavalid=0, bank_we=0, bank_addr=0, bank_wdata=0, go=0, read_mode=0, n_bodies=0, gap=0, res_addr=0, err=0, all staging valid bits=0, done_sticky=0.
- Select codes: GO 0x00, READ 0x01, N_BODIES 0x02, GAP 0x03, X lower/upper 0x04/0x05, Y 0x06/0x07, M 0x08/0x09, VX 0x10/0x11, VY 0x12/0x13, DONE 0x40, READ_X_L 0x41, READ_X_U 0x42, READ_Y_L 0x43, READ_Y_U 0x44. Unmapped writes are ignored; unmapped reads return 0 with readdatavalid.
- Writes take effect on the clk edge where chipselect&write.
  - GO sets go=writedata[0]; READ sets read_mode=writedata[0]; N_BODIES takes writedata[9:0]; GAP takes writedata[31:0].
  - Writing GO=1 clears done_sticky.
- Body lower write: stage[bank] <= writedata[31:0], stage_idx[bank] <= index, stage_v[bank] <= 1. No bank write occurs.
- Body upper write: the next cycle drives bank_we one-hot for that bank, bank_addr=index, bank_wdata={writedata[31:0], stage[bank]}; stage_v[bank] clears.
  - If stage_v=0 or stage_idx!=index: still commits, with lower half forced to 0, and sets err.
  - Banks stage independently, so interleaved X-lower, Y-lower, X-upper, Y-upper is legal.
- A body write while go=1 is dropped: no staging update, no bank_we, err set.
- Holding write with the same addr for N cycles is idempotent: the lower write re-stages; the upper write recommits the same value.
- Reads have 2-cycle latency. Cycle t samples chipselect&read and addr. res_addr=index is registered at t+1; readdata and readdatavalid are registered at t+2.
  - READ_X_L/U returns {32'b0, res_x[31:0]} or {32'b0, res_x[63:32]}; same pattern for Y.
  - DONE returns {61'b0, err, go, done_sticky}.
  - A back-to-back read every cycle is pipelined, one result per cycle.
- done_sticky is set on done_in and cleared by GO=1 or reset. If both occur in the same cycle, set wins.
- Simultaneous read and write in one cycle: the write executes and the read is ignored (no readdatavalid).
- err clears only on reset or on a write to DONE with writedata[0]=1.

Optional Feature:
NBODY_CSR_READBACK_EN
- Defined: reads of GO, READ, N_BODIES and GAP return the zero-extended register value with the same 2-cycle latency.
- Undefined: those reads return 0 with readdatavalid.

Test Plan:
- Reset mid-write (rst during X_UPPER cycle) -> no bank_we pulse, all outputs 0, stage_v cleared.
- N_BODIES=25, GAP=6, GO=1 -> n_bodies=25, gap=6, go=1; a subsequent X_LOWER write sets err=1 and produces no bank_we.
- Body 1 X=-5.0 (0xC014000000000000): lower 0x00000000 then upper 0xC0140000 -> bank_we=5'b00001, bank_addr=1, bank_wdata=0xC014000000000000 one cycle after the upper write.
- Y upper for index 2 with no prior lower -> bank_wdata={upper, 32'h0}, err=1; DONE read returns bit2=1.
- res_x=0x3FF0000000000000, read READ_X_U index 0 at cycle t -> res_addr=0 at t+1; readdata=0x3FF00000 with readdatavalid at t+2.
- done_in pulse -> DONE read returns bit0=1; GO=1 write clears it; done_in coinciding with the GO=1 write leaves bit0=1.
